// File: rtl/rv32_mem_pkg.sv
// Shared encodings for the load/store responder: funct3 sizes, opcodes and FSM states.
package rv32_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for sub-word loads/stores plus misalignment and funct3 legality.
module mem_lane_align
   import rv32_mem_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdword,
   output logic [3:0]  strb,
   output logic [31:0] wdata_sh,
   output logic [31:0] ldata,
   output logic        err
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        illegal;
   logic        misalign;

   always_comb begin
      unique case (addr_lo)
         2'd0:    byte_sel = rdword[7:0];
         2'd1:    byte_sel = rdword[15:8];
         2'd2:    byte_sel = rdword[23:16];
         default: byte_sel = rdword[31:24];
      endcase
      half_sel = addr_lo[1] ? rdword[31:16] : rdword[15:0];
   end

   always_comb begin
      strb     = 4'b0000;
      wdata_sh = 32'h0;
      ldata    = 32'h0;
      illegal  = 1'b0;
      misalign = 1'b0;
      unique case (funct3)
         F3_B: begin
            strb     = 4'b0001 << addr_lo;
            wdata_sh = {4{wdata[7:0]}};
            ldata    = {{24{byte_sel[7]}}, byte_sel};
         end
         F3_H: begin
            misalign = addr_lo[0];
            strb     = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_sh = {2{wdata[15:0]}};
            ldata    = {{16{half_sel[15]}}, half_sel};
         end
         F3_W: begin
            misalign = (addr_lo != 2'b00);
            strb     = 4'b1111;
            wdata_sh = wdata;
            ldata    = rdword;
         end
         // Unsigned variants exist only for loads
         F3_BU: begin
            illegal = we;
            ldata   = {24'h0, byte_sel};
         end
         F3_HU: begin
            illegal  = we;
            misalign = addr_lo[0];
            ldata    = {16'h0, half_sel};
         end
         default: illegal = 1'b1;
      endcase
      err = illegal | misalign;
   end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder: captures a request, waits LATENCY edges,
// commits into a byte-enabled RAM and presents the result on a valid/ready response.
module data_mem_responder
   import rv32_mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   // 33-bit so a window ending exactly at 2^32 still compares correctly
   localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

   mem_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [2:0]    funct3_q, funct3_d;
   logic [1:0]    addr_lo_q, addr_lo_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          rng_err_q, rng_err_d;
   logic [31:0]   rsp_rdata_q, rsp_rdata_d;
   logic          rsp_err_q, rsp_err_d;

   logic [3:0][7:0] mem [DEPTH_WORDS];

   logic [31:0] rdword;
   logic [3:0]  strb;
   logic [31:0] wdata_sh;
   logic [31:0] ldata;
   logic        lane_err;
   logic        acc_err;
   logic        commit;
   logic        out_of_range;

   assign rdword       = mem[idx_q];
   assign acc_err      = rng_err_q | lane_err;
   assign out_of_range = ({1'b0, req_addr} < {1'b0, BASE_ADDR}) || ({1'b0, req_addr} >= END_ADDR);

   mem_lane_align u_align (
      .we       (we_q),
      .funct3   (funct3_q),
      .addr_lo  (addr_lo_q),
      .wdata    (wdata_q),
      .rdword   (rdword),
      .strb     (strb),
      .wdata_sh (wdata_sh),
      .ldata    (ldata),
      .err      (lane_err)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      funct3_d    = funct3_q;
      addr_lo_d   = addr_lo_q;
      idx_d       = idx_q;
      wdata_d     = wdata_q;
      rng_err_d   = rng_err_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      commit      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d      = req_we;
               funct3_d  = req_funct3;
               addr_lo_d = req_addr[1:0];
               idx_d     = AW'((req_addr - BASE_ADDR) >> 2);
               wdata_d   = req_wdata;
               rng_err_d = out_of_range;
               cnt_d     = CW'(LATENCY - 1);
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               commit      = 1'b1;
               rsp_rdata_d = (acc_err || we_q) ? 32'h0 : ldata;
               rsp_err_d   = acc_err;
               state_d     = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_rdata_d = 32'h0;
               rsp_err_d   = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         funct3_q    <= 3'b000;
         addr_lo_q   <= 2'b00;
         idx_q       <= '0;
         wdata_q     <= 32'h0;
         rng_err_q   <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         funct3_q    <= funct3_d;
         addr_lo_q   <= addr_lo_d;
         idx_q       <= idx_d;
         wdata_q     <= wdata_d;
         rng_err_q   <= rng_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Storage is not reset; commit is gated by state so a reset drops pending stores
   always_ff @(posedge clk) begin
      if (commit && we_q && !acc_err) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) mem[idx_q][b] <= wdata_sh[b*8 +: 8];
         end
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: hand-computed load/store vectors and handshake checks.
module tb_data_mem_responder;

   localparam int          DEPTH = 1024;
   localparam int          LAT   = 2;
   localparam logic [31:0] BASE  = 32'h0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int vecs = 0;
   int miss = 0;

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp)
      else begin
         miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request and wait for its response; leaves rsp_valid high if hold is set.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input string tag, input bit hold);
      int n;
      int w;
      @(negedge clk);
      w = 0;
      while (!req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk({tag, " ready"}, 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(posedge clk);
         #1 n++;
      end
      chk({tag, " latency"}, 32'(n), 32'(LAT));
      @(negedge clk);
      chk({tag, " rdata"}, rsp_rdata, exp_rd);
      chk({tag, " err"}, 32'(rsp_err), 32'(exp_err));
      if (!hold) begin
         rsp_ready = 1'b1;
         @(posedge clk);
         #1 rsp_ready = 1'b0;
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      rsp_ready  = 1'b0;
      #3;
      chk("reset req_ready", 32'(req_ready), 32'd1);
      chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset rsp_rdata", rsp_rdata, 32'h0);
      chk("reset rsp_err", 32'(rsp_err), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "SW 10", 1'b0);
      issue(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "LW 10", 1'b0);
      issue(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, "LB 13", 1'b0);
      issue(1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0, "LBU 13", 1'b0);
      issue(1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, "LH 10", 1'b0);
      issue(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, "LHU 12", 1'b0);

      issue(1'b1, 3'b000, 32'h11, 32'h55, 32'h0, 1'b0, "SB 11", 1'b0);
      issue(1'b1, 3'b001, 32'h12, 32'h1234, 32'h0, 1'b0, "SH 12", 1'b0);
      issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0, "LW 10 merged", 1'b0);

      issue(1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1, "LW 11 misalign", 1'b0);
      issue(1'b1, 3'b001, 32'h13, 32'hFFFF, 32'h0, 1'b1, "SH 13 misalign", 1'b0);
      issue(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, "store f3 100", 1'b0);
      issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0, "LW 10 no write", 1'b0);
      issue(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, "load f3 011", 1'b0);
      issue(1'b0, 3'b010, BASE + 32'(4 * DEPTH), 32'h0, 32'h0, 1'b1, "LW range", 1'b0);
      issue(1'b0, 3'b010, BASE + 32'(4 * DEPTH) - 32'd4, 32'h0, 32'h0, 1'b0, "LW last word", 1'b0);
      issue(1'b1, 3'b010, BASE + 32'(4 * DEPTH) - 32'd4, 32'hCAFEF00D, 32'h0, 1'b0, "SW last word", 1'b0);
      issue(1'b0, 3'b010, BASE + 32'(4 * DEPTH) - 32'd4, 32'h0, 32'hCAFEF00D, 1'b0, "LW last rb", 1'b0);

      // Backpressure: response held while a competing store is offered
      issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0, "LW hold", 1'b1);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h10;
      req_wdata  = 32'h0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold rsp_valid", 32'(rsp_valid), 32'd1);
         chk("hold rdata", rsp_rdata, 32'h123455EF);
         chk("hold req_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      chk("release req_ready", 32'(req_ready), 32'd1);
      chk("release rsp_valid", 32'(rsp_valid), 32'd0);
      issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0, "LW after hold", 1'b0);

      // Reset between accept and commit drops the store
      issue(1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0, "SW 20 prior", 1'b0);
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h20;
      req_wdata  = 32'hAAAAAAAA;
      @(posedge clk);
      #1 req_valid = 1'b0;
      chk("accepted busy", 32'(req_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("midrst req_ready", 32'(req_ready), 32'd1);
      chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst rsp_rdata", rsp_rdata, 32'h0);
      chk("midrst rsp_err", 32'(rsp_err), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      issue(1'b0, 3'b010, 32'h20, 32'h0, 32'h11223344, 1'b0, "LW 20 after rst", 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
